// File: rtl/alu_ctrl.sv
// Purpose: two-requester front end for a shared combinational ALU; arbitrates A/B, drives
//          the ALU, waits SETTLE cycles, captures the result and offers it as a response.
// Latency: rsp_valid rises SETTLE cycles after the acceptance edge; one op per SETTLE+2 cycles.
// Backpressure: requests wait (ready low) while busy; the response holds until rsp_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_op/a_in1/a_in2   requester A operation; a_ready = accepted this cycle
//   b_valid/b_op/b_in1/b_in2   requester B operation; b_ready = accepted this cycle
//   alu_op/alu_in1/alu_in2     registered drive to the shared ALU; alu_out = its result
//   rsp_valid/rsp_data/rsp_id  captured result and requester (0=A, 1=B); rsp_ready = taken
//   busy                       high whenever the controller is not idle
//
// Build option: define ALU_CTRL_RR_EN for round-robin arbitration between A and B;
// left undefined, A has fixed priority over B.
// SETTLE must lie in 1..15.

module alu_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [3:0] a_op,
  input  logic [3:0] a_in1,
  input  logic [3:0] a_in2,
  input  logic       b_valid,
  input  logic [3:0] b_op,
  input  logic [3:0] b_in1,
  input  logic [3:0] b_in2,
  output logic       a_ready,
  output logic       b_ready,
  output logic [3:0] alu_in1,
  output logic [3:0] alu_in2,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] alu_in1_q;
  logic [3:0] alu_in2_q;
  logic [3:0] alu_op_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_id_q;
  logic       rst_ok_q;
  logic       grant_b;
  logic       accept;

  // Single-stage release flop: reset is removed asynchronously but the FSM only
  // starts moving once this flop has seen one edge, so the first possible state
  // change lands on the second rising edge after rst_n goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_ok_q <= 1'b0;
    end else begin
      rst_ok_q <= 1'b1;
    end
  end

`ifdef ALU_CTRL_RR_EN
  // 1 = B was granted last; resets to "B last" so the first contest goes to A.
  logic last_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else if (accept) begin
      last_b_q <= grant_b;
    end
  end

  assign grant_b = b_valid && (!a_valid || !last_b_q);
`else
  assign grant_b = b_valid && !a_valid;
`endif

  // Ready is a pure function of the idle state and the request lines, so at most
  // one of a_ready/b_ready can be high and neither is high while busy.
  assign a_ready = rst_ok_q && (state_q == IDLE) && a_valid && !grant_b;
  assign b_ready = rst_ok_q && (state_q == IDLE) && grant_b;
  assign accept  = a_ready || b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      alu_in1_q   <= 4'd0;
      alu_in2_q   <= 4'd0;
      alu_op_q    <= 4'b1111;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_id_q    <= 1'b0;
    end else if (rst_ok_q) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_op_q  <= grant_b ? b_op  : a_op;
            alu_in1_q <= grant_b ? b_in1 : a_in1;
            alu_in2_q <= grant_b ? b_in2 : a_in2;
            rsp_id_q  <= grant_b;
            cnt_q     <= SETTLE_M1;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          // Counter reaches zero on the SETTLE-th edge after acceptance; the
          // ALU inputs have been stable for SETTLE cycles by then.
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= alu_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [3:0] a_op = 4'd0;
  logic [3:0] a_in1 = 4'd0;
  logic [3:0] a_in2 = 4'd0;
  logic       b_valid = 1'b0;
  logic [3:0] b_op = 4'd0;
  logic [3:0] b_in1 = 4'd0;
  logic [3:0] b_in2 = 4'd0;
  logic       a_ready;
  logic       b_ready;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  logic grant_q[$];
  int   acc_q[$];
  exp_t mon_e;

  logic       alu_ovr_en = 1'b0;
  logic [7:0] alu_ovr_val = 8'd0;

  alu_ctrl #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_op(a_op), .a_in1(a_in1), .a_in2(a_in2),
    .b_valid(b_valid), .b_op(b_op), .b_in1(b_in1), .b_in2(b_in2),
    .a_ready(a_ready), .b_ready(b_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Stand-in for the shared ALU.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] i1,
                                           input logic [3:0] i2);
    case (op)
      4'b0011: return {4'b0, i1} + {4'b0, i2};
      4'b0100: return {4'b0, i1} * {4'b0, i2};
      default: return {op ^ i1, i2};
    endcase
  endfunction

  always_comb alu_out = alu_ovr_en ? alu_ovr_val : alu_model(alu_op, alu_in1, alu_in2);

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: sampled 1 time unit before each rising edge, i.e. exactly what
  // that edge will act on.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (a_ready || b_ready) begin
        checks++;
        if (a_ready && b_ready) begin
          errors++;
          $display("FAIL one_ready a_ready=%b b_ready=%b required at most one high", a_ready, b_ready);
        end
      end
      if (a_ready) begin
        sb_q.push_back({1'b0, alu_model(a_op, a_in1, a_in2)});
        grant_q.push_back(1'b0);
        acc_q.push_back(cyc);
      end else if (b_ready) begin
        sb_q.push_back({1'b1, alu_model(b_op, b_in1, b_in2)});
        grant_q.push_back(1'b1);
        acc_q.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got id=%b data=%h required no response", rsp_id, rsp_data);
        end else begin
          mon_e = sb_q.pop_front();
          if (rsp_id !== mon_e.id || rsp_data !== mon_e.data) begin
            errors++;
            $display("FAIL sb_rsp got id=%b data=%h required id=%b data=%h",
                     rsp_id, rsp_data, mon_e.id, mon_e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    a_valid = 1'b1; a_op = 4'b0111; a_in1 = 4'd1; a_in2 = 4'd2;
    repeat (2) @(negedge clk);
    checks++;
    if (alu_op !== 4'b1111 || alu_in1 !== 4'd0 || alu_in2 !== 4'd0) begin
      errors++;
      $display("FAIL rst_alu got op=%b in1=%h in2=%h required 1111/0/0", alu_op, alu_in1, alu_in2);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp got v=%b d=%h id=%b required 0/00/0", rsp_valid, rsp_data, rsp_id);
    end
    checks++;
    if (busy !== 1'b0 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got busy=%b a_ready=%b required 0/0", busy, a_ready);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    // First edge after release: no acceptance yet, ready now open.
    checks++;
    if (busy !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release got busy=%b a_ready=%b required 0/1", busy, a_ready);
    end
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_withdraw got busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_hold();
    int n;
    @(negedge clk);
    a_valid = 1'b1; a_op = 4'b0011; a_in1 = 4'd3; a_in2 = 4'd2;
    b_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got a=%b b=%b required 1/0", a_ready, b_ready);
    end
    @(negedge clk);
    a_valid = 1'b0; a_op = 4'hE; a_in1 = 4'hA; a_in2 = 4'h5;
    #1;
    checks++;
    if (alu_op !== 4'b0011 || alu_in1 !== 4'd3 || alu_in2 !== 4'd2) begin
      errors++;
      $display("FAIL single_drive got op=%b in1=%h in2=%h required 0011/3/2", alu_op, alu_in1, alu_in2);
    end
    checks++;
    if (busy !== 1'b1 || a_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_exec got busy=%b a_ready=%b rsp_valid=%b required 1/0/0", busy, a_ready, rsp_valid);
    end
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != SETTLE) begin
      errors++;
      $display("FAIL single_latency got %0d cycles required %0d", n, SETTLE);
    end
    checks++;
    if (rsp_data !== 8'h05 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL single_data got d=%h id=%b required 05/0", rsp_data, rsp_id);
    end
    alu_ovr_en = 1'b1; alu_ovr_val = 8'h7F;
    b_valid = 1'b1; b_op = 4'b0001; b_in1 = 4'd4; b_in2 = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h05 || busy !== 1'b1 || b_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got v=%b d=%h busy=%b b_ready=%b required 1/05/1/0",
                 i, rsp_valid, rsp_data, busy, b_ready);
      end
    end
    b_valid = 1'b0; alu_ovr_en = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got busy=%b v=%b required 0/0", busy, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL withdrawn_b got busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_g;
    do_reset();
    grant_q.delete();
    acc_q.delete();
    a_valid = 1'b1; a_op = 4'b0011; a_in1 = 4'd5; a_in2 = 4'd6;
    b_valid = 1'b1; b_op = 4'b0100; b_in1 = 4'd7; b_in2 = 4'd3;
    rsp_ready = 1'b1;
    n = 0;
    while (grant_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++;
    if (grant_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d grants required 4", grant_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_CTRL_RR_EN
        exp_g = 1'(i % 2);
`else
        exp_g = 1'b0;
`endif
        checks++;
        if (grant_q[i] !== exp_g) begin
          errors++;
          $display("FAIL b2b_grant_%0d got %b required %b", i, grant_q[i], exp_g);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_q[i] - acc_q[i-1] != SETTLE + 2) begin
          errors++;
          $display("FAIL b2b_spacing_%0d got %0d required %0d", i, acc_q[i] - acc_q[i-1], SETTLE + 2);
        end
      end
    end
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending required 0", sb_q.size());
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    int n;
    logic seen;
    @(negedge clk);
    a_valid = 1'b1; a_op = 4'b0101; a_in1 = 4'd9; a_in2 = 4'd1;
    b_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if (rsp_valid !== 1'b0 || alu_op !== 4'b1111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rexec_async got v=%b op=%b busy=%b required 0/1111/0", rsp_valid, alu_op, busy);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (SETTLE + 4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rexec_no_rsp got rsp_valid seen=%b required 0", seen);
    end
    b_valid = 1'b1; b_op = 4'b0100; b_in1 = 4'd3; b_in2 = 4'd4;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL lone_b_ready got a=%b b=%b required 0/1", a_ready, b_ready);
    end
    @(negedge clk);
    b_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != SETTLE) begin
      errors++;
      $display("FAIL lone_b_latency got %0d cycles required %0d", n, SETTLE);
    end
    checks++;
    if (rsp_id !== 1'b1 || rsp_data !== 8'd12) begin
      errors++;
      $display("FAIL lone_b_data got id=%b d=%h required 1/0c", rsp_id, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lone_b_done got pending=%0d busy=%b required 0/0", sb_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_back_to_back();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter SETTLE, default 2, is the number of cycles the ALU operands and op are held stable before alu_out is sampled (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 a_valid / b_valid  input  1  requester A / B has an operation pending.
REQ-005 a_op, b_op  input  4  ALU op_mode from requester A / B.
REQ-006 a_in1, a_in2, b_in1, b_in2  input  4  operand pairs from requester A / B.
REQ-007 a_ready / b_ready  output  1  request accepted this cycle (combinational).
REQ-008 alu_in1, alu_in2, alu_op  output  4  registered drive to the shared ALU datain1, datain2, op_mode.
REQ-009 alu_out  input  8  ALU result.
REQ-010 rsp_valid  output  1  response holding; rsp_data  output  8  captured result; rsp_id  output  1  0=A, 1=B.
REQ-011 rsp_ready  input  1  consumer takes response; busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, RESP; encoding is implementer's choice.
REQ-013 In IDLE, x_ready SHALL equal x_valid AND (grant==x); at most one ready high per cycle; ready is 0 in EXEC and RESP.
REQ-014 On acceptance edge the block SHALL latch the granted op/in1/in2 into alu_op/alu_in1/alu_in2, latch rsp_id, load counter with SETTLE-1, and go to EXEC.
REQ-015 In EXEC the counter SHALL decrement each cycle; on the edge where counter==0 alu_out SHALL be captured into rsp_data and state SHALL go to RESP.
REQ-016 Latency: rsp_valid SHALL be high exactly SETTLE cycles after the acceptance edge.
REQ-017 In RESP rsp_valid SHALL be 1 and rsp_data/rsp_id SHALL hold stable until the edge with rsp_ready=1, then go to IDLE.
REQ-018 rsp_ready outside RESP SHALL be ignored.
REQ-019 ALU drive outputs SHALL hold their last values in RESP and IDLE (no change until next acceptance).
REQ-020 Throughput: at most one operation per SETTLE+2 cycles; a request pending during EXEC/RESP SHALL wait, never be dropped by the block.
REQ-021 A requester deasserting valid before ready SHALL cause no state change; request fields need only be valid in the ready cycle.
REQ-022 Only one requester valid: that requester SHALL be granted regardless of arbitration mode.
REQ-023 op codes SHALL be passed through unchanged; the block does not decode them.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, counter 0, alu_in1/alu_in2 0, alu_op 4'b1111, rsp_valid 0, rsp_data 0, rsp_id 0, RR pointer "B last".
REQ-025 Reset mid-EXEC or mid-RESP SHALL discard the operation with no response; deassertion SHALL be synchronised so the first state change is on the second edge after rst_n rises.

Configuration
REQ-026 Macro ALU_CTRL_RR_EN defined: both valid in IDLE SHALL grant the requester not granted last; pointer updates on each acceptance; first contest after reset goes to A.
REQ-027 ALU_CTRL_RR_EN undefined: fixed priority, A SHALL always win when both valid; no pointer register.

Verification
REQ-028 A op=0011 in1=3 in2=2, stub alu_out=8'h05, SETTLE=2 -> a_ready one cycle; alu_op=0011, alu_in1=3, alu_in2=2 after edge; rsp_valid two cycles later, rsp_data=05, rsp_id=0.
REQ-029 rsp_ready held 0 for 5 cycles in RESP, alu_out changed to 8'h7F -> rsp_data stays 05, busy=1, b_ready stays 0; rsp_ready=1 -> IDLE next edge.
REQ-030 A and B valid continuously, 4 ops, RR build -> grant order A,B,A,B; fixed build -> A,A,A,A with b_ready never high.
REQ-031 rst_n pulsed low during EXEC -> rsp_valid 0 and alu_op=1111 immediately; no response after release; next request completes normally.
REQ-032 SETTLE=1 and SETTLE=15 builds, op=0100 -> rsp_valid exactly 1 / 15 cycles after acceptance edge.
